// File: rtl/bullet_hit_detect.sv
// Per-pixel bullet/enemy collision detector with per-frame commit, wave FSM and BCD score.
// Optional score logic is built only when GATORGA_SCORE_EN is defined; otherwise score is tied to zero.
module bullet_hit_detect #(
  parameter int N_ENEMY      = 8,
  parameter int SCORE_DIGITS = 4
) (
  input  logic                      pixel_clk,
  input  logic                      rst,
  input  logic                      fsync,
  input  logic                      bullet_active,
  input  logic [N_ENEMY-1:0]        enemy_active,
  input  logic signed [11:0]        hpos,
  input  logic signed [11:0]        vpos,
  output logic [N_ENEMY-1:0]        alive,
  output logic                      hit,
  output logic [N_ENEMY-1:0]        hit_mask,
  output logic                      bullet_kill,
  output logic signed [11:0]        hit_x,
  output logic signed [11:0]        hit_y,
  output logic                      wave_clear,
  output logic [4*SCORE_DIGITS-1:0] score
);

  typedef enum logic {
    PLAY   = 1'b0,
    RELOAD = 1'b1
  } wave_state_t;

  wave_state_t              state_r;
  wave_state_t              state_s;
  logic [N_ENEMY-1:0]       acc_r;
  logic                     first_r;
  logic signed [11:0]       shadow_x_r;
  logic signed [11:0]       shadow_y_r;
  logic [N_ENEMY-1:0]       overlap_s;
  logic [N_ENEMY-1:0]       c_s;
  logic [N_ENEMY-1:0]       alive_next_s;
  logic                     commit_s;
  logic                     any_hit_s;
  logic                     wave_done_s;

  // Overlap detection and commit decode; RELOAD masks all overlaps
  always_comb begin
    overlap_s = {N_ENEMY{1'b0}};
    if (state_r == PLAY) begin
      overlap_s = {N_ENEMY{bullet_active}} & enemy_active & alive;
    end else begin
      overlap_s = {N_ENEMY{1'b0}};
    end
    c_s          = acc_r | overlap_s;
    commit_s     = fsync && (state_r == PLAY);
    any_hit_s    = |c_s;
    alive_next_s = alive & ~c_s;
    wave_done_s  = commit_s && any_hit_s && (alive_next_s == {N_ENEMY{1'b0}});
  end

  // Wave FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      PLAY: begin
        if (wave_done_s) begin
          state_s = RELOAD;
        end else begin
          state_s = PLAY;
        end
      end
      RELOAD: begin
        if (fsync) begin
          state_s = PLAY;
        end else begin
          state_s = RELOAD;
        end
      end
      default: state_s = PLAY;
    endcase
  end

  // Wave FSM state register
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_r <= PLAY;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame accumulation, first-hit shadow and commit of the registered outputs
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      alive       <= {N_ENEMY{1'b1}};
      hit         <= 1'b0;
      bullet_kill <= 1'b0;
      wave_clear  <= 1'b0;
      hit_mask    <= {N_ENEMY{1'b0}};
      hit_x       <= 12'sd0;
      hit_y       <= 12'sd0;
      acc_r       <= {N_ENEMY{1'b0}};
      first_r     <= 1'b0;
      shadow_x_r  <= 12'sd0;
      shadow_y_r  <= 12'sd0;
    end else begin
      hit         <= 1'b0;
      bullet_kill <= 1'b0;
      wave_clear  <= 1'b0;
      if (fsync) begin
        acc_r   <= {N_ENEMY{1'b0}};
        first_r <= 1'b0;
        if (state_r == RELOAD) begin
          alive    <= {N_ENEMY{1'b1}};
          hit_mask <= {N_ENEMY{1'b0}};
        end else begin
          hit_mask   <= c_s;
          alive      <= alive_next_s;
          wave_clear <= wave_done_s;
          if (any_hit_s) begin
            hit         <= 1'b1;
            bullet_kill <= 1'b1;
            // An overlap only on the strobe cycle never reached the shadow
            hit_x       <= first_r ? shadow_x_r : hpos;
            hit_y       <= first_r ? shadow_y_r : vpos;
          end
        end
      end else begin
        acc_r <= c_s;
        if (!first_r && (|overlap_s)) begin
          first_r    <= 1'b1;
          shadow_x_r <= hpos;
          shadow_y_r <= vpos;
        end
      end
    end
  end

`ifdef GATORGA_SCORE_EN
  localparam int PW = $clog2(N_ENEMY*2+1);
  localparam logic [4*SCORE_DIGITS-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

  function automatic logic [PW-1:0] popcount(input logic [N_ENEMY-1:0] v);
    logic [PW-1:0] cnt;
    cnt = {PW{1'b0}};
    for (int i = 0; i < N_ENEMY; i++) begin
      cnt = cnt + PW'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [4*SCORE_DIGITS-1:0] bcd_inc(input logic [4*SCORE_DIGITS-1:0] v);
    logic [4*SCORE_DIGITS-1:0] r;
    logic                      carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry && (v[4*i+:4] == 4'd9)) begin
        r[4*i+:4] = 4'd0;
      end else if (carry) begin
        r[4*i+:4] = v[4*i+:4] + 4'd1;
        carry     = 1'b0;
      end else begin
        r[4*i+:4] = v[4*i+:4];
      end
    end
    return r;
  endfunction

  logic [PW-1:0]             pending_r;
  logic [PW-1:0]             pending_s;
  logic [4*SCORE_DIGITS-1:0] score_r;

  // Drain one kill per cycle; a same-cycle commit adds its popcount on top
  always_comb begin
    pending_s = pending_r;
    if (pending_r != {PW{1'b0}}) begin
      pending_s = pending_r - PW'(1'b1);
    end else begin
      pending_s = pending_r;
    end
    if (commit_s) begin
      pending_s = pending_s + popcount(c_s);
    end else begin
      pending_s = pending_s;
    end
  end

  // Pending counter and saturating BCD score
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pending_r <= {PW{1'b0}};
      score_r   <= {(4*SCORE_DIGITS){1'b0}};
    end else begin
      pending_r <= pending_s;
      if ((pending_r != {PW{1'b0}}) && (score_r != SCORE_MAX)) begin
        score_r <= bcd_inc(score_r);
      end
    end
  end

  assign score = score_r;
`else
  assign score = {(4*SCORE_DIGITS){1'b0}};
`endif

endmodule
